// File: rtl/register_file_pkg.sv
// Shared register-file constants: default widths and the hardwired-zero register index.
package register_file_pkg;

  localparam int RF_DWIDTH = 32;
  localparam int RF_AWIDTH = 5;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/register_file_if.sv
// Writeback-commit and decode-read signals of the architectural register file.
interface register_file_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);

  logic              rf_i_wr_ce;
  logic              rf_i_we;
  logic [AWIDTH-1:0] rf_i_wr_addr;
  logic [DWIDTH-1:0] rf_i_wr_data;
  logic              rf_i_rd_ce;
  logic [AWIDTH-1:0] rf_i_rs1_addr;
  logic [AWIDTH-1:0] rf_i_rs2_addr;
  logic              rf_i_stall;
  logic              rf_i_flush;
  logic [DWIDTH-1:0] rf_o_rs1_data;
  logic [DWIDTH-1:0] rf_o_rs2_data;
  logic [AWIDTH-1:0] rf_o_rs1_addr;
  logic [AWIDTH-1:0] rf_o_rs2_addr;
  logic              rf_o_ce;

  modport master (
    output rf_i_wr_ce, rf_i_we, rf_i_wr_addr, rf_i_wr_data,
    output rf_i_rd_ce, rf_i_rs1_addr, rf_i_rs2_addr, rf_i_stall, rf_i_flush,
    input  rf_o_rs1_data, rf_o_rs2_data, rf_o_rs1_addr, rf_o_rs2_addr, rf_o_ce
  );

  modport slave (
    input  rf_i_wr_ce, rf_i_we, rf_i_wr_addr, rf_i_wr_data,
    input  rf_i_rd_ce, rf_i_rs1_addr, rf_i_rs2_addr, rf_i_stall, rf_i_flush,
    output rf_o_rs1_data, rf_o_rs2_data, rf_o_rs1_addr, rf_o_rs2_addr, rf_o_ce
  );

endinterface

// File: rtl/register_file_rf_read_port.sv
// One registered read port: operand capture with write bypass, stall hold with refresh, flush clear.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int DWIDTH = RF_DWIDTH,
  parameter int AWIDTH = RF_AWIDTH
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              rd_ce,
  input  logic              stall,
  input  logic              flush,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] rd_mem_data,
  input  logic              wr_commit,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] data_reg,
  output logic [AWIDTH-1:0] addr_reg
);

  logic [DWIDTH-1:0] operand;
  logic [DWIDTH-1:0] data_next;
  logic [AWIDTH-1:0] addr_next;
  logic              held_hit;

  always_comb begin
    operand = rd_mem_data;
    if (rd_addr == AWIDTH'(ZERO_REG)) begin
      operand = '0;
    end else if (wr_commit && (wr_addr == rd_addr)) begin
      operand = wr_data;
    end
  end

  // A retiring producer of the held register must not leave decode with a stale operand.
  assign held_hit = wr_commit && (wr_addr == addr_reg) && (addr_reg != AWIDTH'(ZERO_REG));

  always_comb begin
    data_next = data_reg;
    addr_next = addr_reg;
    if (flush) begin
      data_next = '0;
      addr_next = '0;
    end else if (stall) begin
      if (held_hit) begin
        data_next = wr_data;
      end
    end else if (rd_ce) begin
      data_next = operand;
      addr_next = rd_addr;
    end else begin
      data_next = '0;
      addr_next = '0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      data_reg <= '0;
      addr_reg <= '0;
    end else begin
      data_reg <= data_next;
      addr_reg <= addr_next;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural integer register file: writeback commit port plus two registered decode read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DWIDTH = RF_DWIDTH,
  parameter int AWIDTH = RF_AWIDTH
) (
  input logic          wb_clk,
  input logic          wb_rst,
  register_file_if.slave rf_bus
);

  localparam int NUM_REGS  = 2 ** AWIDTH;
  localparam int NUM_PORTS = 2;

  // Flop array rather than RAM so that the asynchronous clear reaches every entry.
  logic [DWIDTH-1:0] mem_reg [NUM_REGS];
  logic              wr_commit;
  logic              ce_reg;
  logic              ce_next;

  logic [AWIDTH-1:0] rd_addr   [NUM_PORTS];
  logic [DWIDTH-1:0] port_data [NUM_PORTS];
  logic [AWIDTH-1:0] port_addr [NUM_PORTS];

  assign wr_commit = rf_bus.rf_i_wr_ce && rf_bus.rf_i_we &&
                     (rf_bus.rf_i_wr_addr != AWIDTH'(ZERO_REG));

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_commit) begin
      mem_reg[rf_bus.rf_i_wr_addr] <= rf_bus.rf_i_wr_data;
    end
  end

  always_comb begin
    ce_next = ce_reg;
    if (rf_bus.rf_i_flush) begin
      ce_next = 1'b0;
    end else if (!rf_bus.rf_i_stall) begin
      ce_next = rf_bus.rf_i_rd_ce;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      ce_reg <= 1'b0;
    end else begin
      ce_reg <= ce_next;
    end
  end

  assign rd_addr[0] = rf_bus.rf_i_rs1_addr;
  assign rd_addr[1] = rf_bus.rf_i_rs2_addr;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      rf_read_port #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
      ) u_rf_read_port (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .rd_ce       (rf_bus.rf_i_rd_ce),
        .stall       (rf_bus.rf_i_stall),
        .flush       (rf_bus.rf_i_flush),
        .rd_addr     (rd_addr[gi]),
        .rd_mem_data (mem_reg[rd_addr[gi]]),
        .wr_commit   (wr_commit),
        .wr_addr     (rf_bus.rf_i_wr_addr),
        .wr_data     (rf_bus.rf_i_wr_data),
        .data_reg    (port_data[gi]),
        .addr_reg    (port_addr[gi])
      );
    end
  endgenerate

  assign rf_bus.rf_o_ce        = ce_reg;
  assign rf_bus.rf_o_rs1_data  = port_data[0];
  assign rf_bus.rf_o_rs2_data  = port_data[1];
  assign rf_bus.rf_o_rs1_addr  = port_addr[0];
  assign rf_bus.rf_o_rs2_addr  = port_addr[1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: per-cycle comparison against a behavioural model plus literal checks.
module tb_register_file;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 wb_clk = ~wb_clk;

  register_file_if #(.DWIDTH(32), .AWIDTH(5)) rf_bus ();

  register_file #(.DWIDTH(32), .AWIDTH(5)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .rf_bus (rf_bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Behavioural model: architectural state and expected output registers.
  logic [31:0] m_mem [32];
  logic        m_ce;
  logic [31:0] m_d1, m_d2;
  logic [4:0]  m_a1, m_a2;
  wire         m_commit = rf_bus.rf_i_wr_ce && rf_bus.rf_i_we && (rf_bus.rf_i_wr_addr != 5'd0);

  function automatic logic [31:0] m_value(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (m_commit && rf_bus.rf_i_wr_addr == a) return rf_bus.rf_i_wr_data;
    return m_mem[a];
  endfunction

  always @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
      m_ce <= 1'b0; m_d1 <= 32'h0; m_d2 <= 32'h0; m_a1 <= 5'd0; m_a2 <= 5'd0;
    end else begin
      if (rf_bus.rf_i_flush) begin
        m_ce <= 1'b0; m_d1 <= 32'h0; m_d2 <= 32'h0; m_a1 <= 5'd0; m_a2 <= 5'd0;
      end else if (rf_bus.rf_i_stall) begin
        if (m_commit && m_a1 != 5'd0 && rf_bus.rf_i_wr_addr == m_a1) m_d1 <= rf_bus.rf_i_wr_data;
        if (m_commit && m_a2 != 5'd0 && rf_bus.rf_i_wr_addr == m_a2) m_d2 <= rf_bus.rf_i_wr_data;
      end else if (rf_bus.rf_i_rd_ce) begin
        m_ce <= 1'b1;
        m_d1 <= m_value(rf_bus.rf_i_rs1_addr);
        m_d2 <= m_value(rf_bus.rf_i_rs2_addr);
        m_a1 <= rf_bus.rf_i_rs1_addr;
        m_a2 <= rf_bus.rf_i_rs2_addr;
      end else begin
        m_ce <= 1'b0; m_d1 <= 32'h0; m_d2 <= 32'h0; m_a1 <= 5'd0; m_a2 <= 5'd0;
      end
      if (m_commit) m_mem[rf_bus.rf_i_wr_addr] <= rf_bus.rf_i_wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge wb_clk) begin
    if (check_en) begin
      chk("model_ce",  32'(rf_bus.rf_o_ce),       32'(m_ce));
      chk("model_d1",  rf_bus.rf_o_rs1_data,      m_d1);
      chk("model_d2",  rf_bus.rf_o_rs2_data,      m_d2);
      chk("model_a1",  32'(rf_bus.rf_o_rs1_addr), 32'(m_a1));
      chk("model_a2",  32'(rf_bus.rf_o_rs2_addr), 32'(m_a2));
    end
  end

  task automatic drive(input logic rd_ce, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic wr_ce, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic stall, input logic flush);
    rf_bus.rf_i_rd_ce    = rd_ce;
    rf_bus.rf_i_rs1_addr = rs1;
    rf_bus.rf_i_rs2_addr = rs2;
    rf_bus.rf_i_wr_ce    = wr_ce;
    rf_bus.rf_i_we       = we;
    rf_bus.rf_i_wr_addr  = wa;
    rf_bus.rf_i_wr_data  = wd;
    rf_bus.rf_i_stall    = stall;
    rf_bus.rf_i_flush    = flush;
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic lit(input string name, input logic ce, input logic [31:0] d1, input logic [31:0] d2);
    chk({name, "_ce"}, 32'(rf_bus.rf_o_ce), 32'(ce));
    chk({name, "_d1"}, rf_bus.rf_o_rs1_data, d1);
    chk({name, "_d2"}, rf_bus.rf_o_rs2_data, d2);
    $display("txn %s: ce=%0b rs1=%h rs2=%h", name, rf_bus.rf_o_ce, rf_bus.rf_o_rs1_data, rf_bus.rf_o_rs2_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    #2 wb_rst = 1'b0;
    #1 check_en = 1'b1;
    lit("reset", 1'b0, 32'h0, 32'h0);
    #19 wb_rst = 1'b1;

    drive(1, 1, 2, 0, 0, 0, 32'h0, 0, 0);                    step(); lit("read_x1_x2", 1, 32'h0, 32'h0);
    drive(1, 5, 0, 1, 1, 5, 32'hDEADBEEF, 0, 0);             step(); lit("bypass_x5", 1, 32'hDEADBEEF, 32'h0);
    chk("bypass_a1", 32'(rf_bus.rf_o_rs1_addr), 32'd5);
    drive(1, 5, 5, 0, 0, 0, 32'h0, 0, 0);                    step(); lit("array_x5", 1, 32'hDEADBEEF, 32'hDEADBEEF);
    drive(1, 31, 31, 1, 1, 31, 32'hCAFEF00D, 0, 0);          step(); lit("bypass_x31_both", 1, 32'hCAFEF00D, 32'hCAFEF00D);
    drive(0, 0, 0, 1, 1, 0, 32'h12345678, 0, 0);             step(); lit("write_x0_idle", 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);                    step(); lit("read_x0", 1, 32'h0, 32'h0);
    drive(1, 0, 31, 1, 1, 0, 32'h0BAD0BAD, 0, 0);            step(); lit("x0_bypass_blocked", 1, 32'h0, 32'hCAFEF00D);
    drive(0, 0, 0, 1, 1, 7, 32'h1, 0, 0);                    step(); lit("write_x7", 0, 32'h0, 32'h0);
    drive(1, 7, 5, 0, 0, 0, 32'h0, 0, 0);                    step(); lit("capture_x7", 1, 32'h1, 32'hDEADBEEF);
    drive(1, 3, 3, 1, 1, 7, 32'hA5A5A5A5, 1, 0);             step(); lit("stall_refresh", 1, 32'hA5A5A5A5, 32'hDEADBEEF);
    chk("stall_a1", 32'(rf_bus.rf_o_rs1_addr), 32'd7);
    drive(1, 3, 3, 1, 1, 12, 32'h00000123, 1, 0);            step(); lit("stall_hold", 1, 32'hA5A5A5A5, 32'hDEADBEEF);
    drive(1, 9, 9, 1, 1, 9, 32'h55, 1, 1);                   step(); lit("flush_write", 0, 32'h0, 32'h0);
    chk("flush_a1", 32'(rf_bus.rf_o_rs1_addr), 32'd0);
    drive(1, 9, 12, 0, 0, 0, 32'h0, 0, 0);                   step(); lit("read_x9", 1, 32'h55, 32'h123);
    drive(0, 0, 0, 0, 1, 3, 32'h77, 0, 0);                   step(); lit("we_no_wrce", 0, 32'h0, 32'h0);
    drive(1, 3, 7, 0, 0, 0, 32'h0, 0, 0);                    step(); lit("read_x3", 1, 32'h0, 32'hA5A5A5A5);
    drive(1, 5, 5, 0, 0, 0, 32'h0, 0, 0);                    step(); lit("pre_reset_x5", 1, 32'hDEADBEEF, 32'hDEADBEEF);

    drive(1, 5, 5, 0, 0, 0, 32'h0, 1, 0);
    wb_rst = 1'b0;
    #2;
    lit("async_reset", 0, 32'h0, 32'h0);
    chk("async_reset_a1", 32'(rf_bus.rf_o_rs1_addr), 32'd0);
    #5 wb_rst = 1'b1;
    drive(1, 5, 31, 0, 0, 0, 32'h0, 0, 0);                   step(); lit("post_reset_x5", 1, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);                    step(); lit("final_idle", 0, 32'h0, 32'h0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
